fip_32_seq_div: RTL and testbench

Multi-cycle signed Q16.16 fixed-point divider. It is the inverse of the fixed-point multiplier and replaces the combinational divide in the ray-tracing datapath, for example in ray-plane t = num/den and barycentric normalisation. It uses iterative restoring division on magnitudes, one quotient bit per clock, behind a valid/ready handshake on both sides. The result saturates and carries status flags (overflow, divide-by-zero, underflow).

---
 rtl/fip_pkg.sv | 18 +
 rtl/fip_32_seq_div.sv | 156 +++++++++++++++
 tb/tb_fip_32_seq_div.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fip_pkg.sv
// Shared Q16.16 fixed-point types and saturation limits for the fip arithmetic blocks.
package fip_pkg;

    localparam int unsigned FIP_WIDTH = 32;
    localparam int unsigned FIP_FRAC  = 16;

    localparam logic [31:0] FIP_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] FIP_MIN = 32'h8000_0000;

    typedef logic signed [31:0] fip_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } fip_div_state_e;

endpackage

// File: rtl/fip_32_seq_div.sv
// Signed Q16.16 divider: restoring division on magnitudes, one quotient bit per clock,
// followed by sign restoration, saturation and status flags.
module fip_32_seq_div
    import fip_pkg::*;
#(
    parameter int unsigned WIDTH     = FIP_WIDTH,
    parameter int unsigned FRAC_BITS = FIP_FRAC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             underflow
);

    localparam int unsigned ITERS = WIDTH + FRAC_BITS;
    localparam int unsigned CNT_W = $clog2(ITERS);

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [ITERS-1:0] POS_LIM = {{FRAC_BITS{1'b0}}, SAT_MAX};
    localparam logic [ITERS-1:0] NEG_LIM = {{FRAC_BITS{1'b0}}, SAT_MIN};

    fip_div_state_e state_q, state_d;

    logic [ITERS-1:0] sr_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sign_q;
    logic             dvd_zero_q;
    logic             dvd_neg_q;
    logic             dvs_zero_q;

    logic             accept;
    logic             last;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH+1:0] rem_shift;
    logic             ge;
    logic [WIDTH:0]   rem_step;
    logic [ITERS-1:0] sr_step;
    logic [WIDTH-1:0] res_quot;
    logic             res_ovf;
    logic             res_dbz;
    logic             res_unf;

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned
    always_comb begin
        dvd_mag = dividend[WIDTH-1] ? WIDTH'(-dividend) : dividend;
        dvs_mag = divisor[WIDTH-1]  ? WIDTH'(-divisor)  : divisor;
    end

    // One restoring step; the shift register holds remaining dividend bits above quotient bits
    always_comb begin
        rem_shift = {rem_q, sr_q[ITERS-1]};
        ge        = rem_shift >= {2'b00, dvs_q};
        rem_step  = ge ? (WIDTH+1)'(rem_shift - {2'b00, dvs_q}) : rem_shift[WIDTH:0];
        sr_step   = {sr_q[ITERS-2:0], ge};
    end

    // Final result from the magnitude produced by the last step
    always_comb begin
        res_quot = '0;
        res_ovf  = 1'b0;
        res_dbz  = 1'b0;
        res_unf  = 1'b0;
        if (dvs_zero_q) begin
            res_dbz = 1'b1;
            if (!dvd_zero_q) begin
                res_quot = dvd_neg_q ? SAT_MIN : SAT_MAX;
            end
        end else if (!sign_q && (sr_step > POS_LIM)) begin
            res_quot = SAT_MAX;
            res_ovf  = 1'b1;
        end else if (sign_q && (sr_step > NEG_LIM)) begin
            res_quot = SAT_MIN;
            res_ovf  = 1'b1;
        end else begin
            res_quot = sign_q ? WIDTH'(WIDTH'(0) - sr_step[WIDTH-1:0]) : sr_step[WIDTH-1:0];
            res_unf  = !dvd_zero_q && (sr_step == '0);
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = cnt_q == CNT_W'(ITERS - 1);
        case (state_q)
            IDLE: begin
                accept = in_valid && in_ready;
                if (accept) state_d = CALC;
            end
            CALC: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            underflow   <= 1'b0;
            sr_q        <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            dvd_zero_q  <= 1'b0;
            dvd_neg_q   <= 1'b0;
            dvs_zero_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= state_d == IDLE;
            out_valid <= state_d == DONE;
            if (accept) begin
                sign_q     <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                dvd_zero_q <= dividend == '0;
                dvd_neg_q  <= dividend[WIDTH-1];
                dvs_zero_q <= divisor == '0;
                dvs_q      <= dvs_mag;
                sr_q       <= {dvd_mag, {FRAC_BITS{1'b0}}};
                rem_q      <= '0;
                cnt_q      <= '0;
            end
            if (state_q == CALC) begin
                rem_q <= rem_step;
                sr_q  <= sr_step;
                cnt_q <= cnt_q + CNT_W'(1);
                if (last) begin
                    quotient    <= res_quot;
                    overflow    <= res_ovf;
                    div_by_zero <= res_dbz;
                    underflow   <= res_unf;
                end
            end
        end
    end

endmodule

// File: tb/tb_fip_32_seq_div.sv
// Scoreboard bench for fip_32_seq_div against a wide-integer arithmetic reference.
module tb_fip_32_seq_div;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic        overflow;
    logic        div_by_zero;
    logic        underflow;

    fip_32_seq_div dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .overflow    (overflow),
        .div_by_zero (div_by_zero),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic        ovf;
        logic        dbz;
        logic        unf;
        longint      acc;
    } exp_t;

    exp_t   sb[$];
    int     tests = 0;
    int     fails = 0;
    longint cyc = 0;
    int     rdy_mode = 0;   // 0 random, 1 hold low, 2 always high

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: exact quotient of (a * 2^16) / b truncated toward zero, then saturated
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint num;
        longint t;
        e.a = a; e.b = b; e.q = '0; e.ovf = 0; e.dbz = 0; e.unf = 0; e.acc = 0;
        if (b == 0) begin
            e.dbz = 1;
            if (a == 0)                   e.q = 32'h0000_0000;
            else if ($signed(a) < 0)      e.q = 32'h8000_0000;
            else                          e.q = 32'h7FFF_FFFF;
        end else begin
            num = longint'($signed(a)) * 65536;
            t   = num / longint'($signed(b));
            if (t > 64'sd2147483647) begin
                e.q = 32'h7FFF_FFFF; e.ovf = 1;
            end else if (t < -64'sd2147483648) begin
                e.q = 32'h8000_0000; e.ovf = 1;
            end else begin
                e.q   = 32'(t);
                e.unf = (a != 0) && (t == 0);
            end
        end
        return e;
    endfunction

    // out_ready changes just after the rising edge, away from sampling
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1:       out_ready = 1'b0;
            2:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: pops on the first cycle of each result, then checks it stays stable
    logic        seen = 1'b0;
    logic [34:0] held;
    always @(negedge clk) begin
        if (reset || !out_valid) begin
            seen = 1'b0;
        end else if (!seen) begin
            seen = 1'b1;
            held = {quotient, overflow, div_by_zero, underflow};
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("quot %h/%h", e.a, e.b), 64'(quotient), 64'(e.q));
                chk($sformatf("flags %h/%h", e.a, e.b),
                    64'({overflow, div_by_zero, underflow}), 64'({e.ovf, e.dbz, e.unf}));
                chk("latency", 64'(cyc - e.acc), 64'd48);
                chk("in_ready_in_done", 64'(in_ready), 64'd0);
            end
        end else begin
            chk("hold_stable", 64'({quotient, overflow, div_by_zero, underflow}), 64'(held));
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 64'(in_ready), 64'd1);
            return;
        end
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        e        = model(a, b);
        e.acc    = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    task automatic wait_out_valid();
        int n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("out_valid_timeout", 64'(out_valid), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        exp_t        dropped;
        reset     = 1'b1;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_outputs", 64'({quotient, overflow, div_by_zero, underflow}), 64'd0);
        reset = 1'b0;

        // Directed cases
        issue(32'h0003_0000, 32'h0002_0000);
        issue(32'hFFF8_8000, 32'h0002_8000);
        issue(32'h0001_0000, 32'h0003_0000);
        issue(32'h4000_0000, 32'h0000_0100);
        issue(32'hC000_0000, 32'h0000_0100);
        issue(32'h0005_0000, 32'h0000_0000);
        issue(32'hFFFB_0000, 32'h0000_0000);
        issue(32'h0000_0000, 32'h0000_0000);
        issue(32'h0000_0001, 32'h0002_0000);
        issue(32'h8000_0000, 32'h0001_0000);
        issue(32'h8000_0000, 32'hFFFF_0000);
        issue(32'hFFFF_FFFF, 32'h0002_0000);
        issue(32'h0000_0000, 32'hFFFD_0000);

        // Output back-pressure with ignored in_valid pulses
        wait (sb.size() == 0);
        rdy_mode = 1;
        issue(32'h0005_0000, 32'hFFFD_0000);
        wait_out_valid();
        repeat (10) begin
            @(negedge clk);
            in_valid = 1'b1;
            dividend = $urandom;
            divisor  = $urandom;
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_out_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        rdy_mode = 2;
        @(negedge clk);
        chk("pre_hs_out_valid", 64'(out_valid), 64'd1);
        chk("pre_hs_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("post_hs_in_ready", 64'(in_ready), 64'd1);
        chk("post_hs_out_valid", 64'(out_valid), 64'd0);
        rdy_mode = 0;

        // Reset during iteration 20 drops the pending result
        issue(32'h0007_0000, 32'h0002_0000);
        repeat (19) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        dropped = sb.pop_front();
        @(negedge clk);
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_in_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        issue(32'h0007_0000, 32'h0002_0000);

        // Randomized operands across magnitudes and signs
        for (int i = 0; i < 60; i++) begin
            a = $urandom >> $urandom_range(0, 31);
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) a = -a;
            if ($urandom_range(0, 1) == 1) b = -b;
            if ($urandom_range(0, 15) == 0) b = '0;
            if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
            issue(a, b);
        end

        begin
            int n = 0;
            while (sb.size() != 0 && n < 1000) begin
                @(negedge clk);
                n++;
            end
            if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
        end
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
